// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters, with PSR capture.
// Optional ALU_ARB_LOCK_EN: an op accepted with req_lock=1 keeps the grant on its owner.
module alu_arbiter #(
   parameter int WIDTH = 16,
   parameter int PSR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [7:0]         req_alucont,
   input  logic [1:0]         req_flag_wr,
   input  logic [1:0]         req_lock,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic [PSR_W-1:0]   rsp_psr,
   output logic [PSR_W-1:0]   psr_q,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [3:0]         alu_alucont,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic [PSR_W-1:0]   alu_psr
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state;
   logic ptr, id, flag_wr_q, gnt, unused;
   logic [PSR_W-1:0] flags;
`ifdef ALU_ARB_LOCK_EN
   logic lock_op, lock_q;
   assign gnt = lock_q ? id : (&req_valid ? ptr : req_valid[1]);
   assign unused = ^alu_psr[PSR_W-1:5];
`else
   assign gnt = &req_valid ? ptr : req_valid[1];
   assign unused = ^{alu_psr[PSR_W-1:5], req_lock};
`endif
   assign flags = {{(PSR_W-5){1'b0}}, alu_psr[4:0]};
   // rst_n gating keeps req_ready low while reset is held, even with valid requests
   assign req_ready = (state == IDLE && rst_n && req_valid[gnt]) ? {gnt, ~gnt} : 2'b00;
   assign rsp_valid = (state == RESP) ? {id, ~id} : 2'b00;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 1'b0;
         id          <= 1'b0;
         flag_wr_q   <= 1'b0;
         rsp_result  <= '0;
         rsp_psr     <= '0;
         psr_q       <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_alucont <= '0;
`ifdef ALU_ARB_LOCK_EN
         lock_op     <= 1'b0;
         lock_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (|req_ready) begin
               alu_a       <= gnt ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
               alu_b       <= gnt ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
               alu_alucont <= gnt ? req_alucont[7:4] : req_alucont[3:0];
               flag_wr_q   <= req_flag_wr[gnt];
               id          <= gnt;
`ifdef ALU_ARB_LOCK_EN
               lock_op     <= req_lock[gnt];
`endif
               state       <= EXEC;
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_psr    <= flags;
               if (flag_wr_q) psr_q <= flags;
               state      <= RESP;
            end
            RESP: if (rsp_ready[id]) begin
`ifdef ALU_ARB_LOCK_EN
               ptr    <= lock_op ? ptr : ~id;
               lock_q <= lock_op;
`else
               ptr    <= ~id;
`endif
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 16-bit ALU datapath between two requesters, e.g. execute stage (port 0) and address/PC unit (port 1).
- Arbitrates round-robin and registers the winning operands into the ALU.
- Captures result and PSR {3'b0,Z,C,F,N,L}, returns them over a valid/ready response channel, and maintains the architectural PSR register.
- Sits between the pipeline control and the ALU instance; the ALU stays purely combinational.

Parameters:
- WIDTH, 16, operand/result width.
- PSR_W, 8, PSR width; bits [7:5] always 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester operation request.
- req_ready  out  2  per-requester accept.
- req_a  in  2*WIDTH  operand a per requester; requester i uses [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand b (dst) per requester.
- req_alucont  in  8  4-bit opcode extension per requester.
- req_flag_wr  in  2  1 = update architectural PSR with this op's flags.
- req_lock  in  2  hold grant after this op (used only with ALU_ARB_LOCK_EN).
- rsp_valid  out  2  response valid, one-hot to the owning requester.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_psr  out  PSR_W  captured ALU flags of this op.
- psr_q  out  PSR_W  architectural PSR.
- alu_a, alu_b  out  WIDTH  to ALU a/b.
- alu_alucont  out  4  to ALU alucont.
- alu_result  in  WIDTH  from ALU.
- alu_psr  in  PSR_W  from ALU.

Behaviour:
- Reset:
  - Applies immediately, asynchronously, including mid-operation; any in-flight op is dropped without a response.
  - State=IDLE; all outputs 0; priority pointer=0; lock released.
- FSM states IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. A single valid requester wins. If both are valid, the requester indicated by the pointer wins.
  - req_ready[grant]=1 only in IDLE; the other bit is 0.
  - On req_valid&req_ready: latch a, b, alucont, flag_wr, lock and grant id; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_alucont are registered and already hold the latched operands.
  - At the cycle's end, capture alu_result into rsp_result and alu_psr into rsp_psr, with bits [7:5] forced to 0.
  - If flag_wr, psr_q <= captured flags in the same edge; otherwise psr_q is unchanged.
  - Go to RESP.
- RESP:
  - rsp_valid[id]=1 and stable, together with rsp_result and rsp_psr, until rsp_ready[id].
  - rsp_ready of the other requester is ignored.
  - On handshake: pointer <= ~id (round-robin) and go to IDLE.
- Latency:
  - Accept in cycle N -> rsp_valid in cycle N+2.
  - Minimum 3 cycles per op; no pipelining.
- alu_* outputs hold their last value outside EXEC. rsp_result/rsp_psr hold until the next capture.
- Request inputs are sampled only at the accept edge. Later changes to operands, or deassertion of req_valid, have no effect on the latched op.
- Simultaneous response handshake and new request: the request is not accepted until IDLE (next cycle).
- No arithmetic is performed here; width is passed through unchanged.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined: if the latched op had lock=1, the pointer is not rotated and grant is forced to the same id in following IDLE cycles. The other requester sees req_ready=0 even if the owner is idle. Lock releases when the owner completes an op accepted with lock=0. This supports CMP-then-dependent-op sequences.
- Undefined: req_lock is ignored and pure round-robin applies.
- Port list is identical in both builds.

Test Plan:
- ADD collision case:
  - Stimulus: req0 a=FFFF, b=0001, alucont=0101, flag_wr=1.
  - Response: req_ready0=1 at accept cycle N. rsp_valid0 at N+2 with result=0000, rsp_psr=00011000. psr_q=00011000 from N+2.
- Round-robin:
  - Stimulus: both requests valid continuously after reset, with rsp_ready held high.
  - Response: grant order 0,1,0,1. rsp_valid is never asserted to both requesters at once.
- Flag write suppressed:
  - Stimulus: SUB req1 a=0003, b=0006, alucont=1001, flag_wr=0, with psr_q previously 00011000.
  - Response: rsp_result=FFFD, rsp_psr=00001011, psr_q stays 00011000.
- Response backpressure:
  - Stimulus: rsp_ready0=0 for 5 cycles.
  - Response: rsp_valid0, result and psr stable for all 5 cycles. req_ready=00 throughout. IDLE is reached the cycle after rsp_ready0=1.
- Reset mid-operation:
  - Stimulus: rst_n low during EXEC.
  - Response: all outputs 0 immediately. No rsp_valid after release. Next accept goes to requester 0 when both request.
- Lock (ALU_ARB_LOCK_EN):
  - Stimulus: req0 lock=1 op, then req0 lock=0 op, with req1 valid throughout.
  - Response: req1 is not granted until req0's unlock op response completes; then req1 is granted next.
